// File: rtl/cluster_req_dispatch.sv
// rtl/cluster_req_dispatch.sv - request fork / in-order response join between the core and NrClusters Ara instances
//
// Purpose:
//   Forks each upstream request to every cluster in the active mask, bounded by
//   MaxOutstanding credits. Per-cluster responses are buffered in FIFOs and merged
//   into one upstream response once every active cluster has a response at its head.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   active_mask_i           requested active clusters (sampled while idle)
//   req_*                   upstream request (valid/ready/data)
//   clu_req_*               per-cluster request fan-out
//   clu_resp_*              per-cluster responses {data, err}
//   resp_*                  merged response
//   outstanding_o           issued-but-unmerged request count
//   busy_o                  requests outstanding or a fork partially done
//   mismatch_o              sticky data-mismatch flag between active heads
//
// Optional feature macro: CLUSTER_DISPATCH_MISMATCH_CHECK_EN
//   defined   -> cross-cluster data comparators drive mismatch_o
//   undefined -> no comparators, mismatch_o tied to 0

module cluster_req_dispatch #(
    parameter int unsigned NrClusters     = 4,
    parameter int unsigned ReqWidth       = 128,
    parameter int unsigned RespWidth      = 64,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NrClusters-1:0]           active_mask_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [ReqWidth-1:0]             req_data_i,
    output logic [NrClusters-1:0]           clu_req_valid_o,
    input  logic [NrClusters-1:0]           clu_req_ready_i,
    output logic [NrClusters*ReqWidth-1:0]  clu_req_data_o,
    input  logic [NrClusters-1:0]           clu_resp_valid_i,
    output logic [NrClusters-1:0]           clu_resp_ready_o,
    input  logic [NrClusters*RespWidth-1:0] clu_resp_data_i,
    input  logic [NrClusters-1:0]           clu_resp_err_i,
    output logic                            resp_valid_o,
    input  logic                            resp_ready_i,
    output logic [RespWidth-1:0]            resp_data_o,
    output logic                            resp_err_o,
    output logic [CntWidth-1:0]             outstanding_o,
    output logic                            busy_o,
    output logic                            mismatch_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);
    localparam logic [PtrW-1:0]     LastPtr = PtrW'(MaxOutstanding - 1);

    logic [NrClusters-1:0] mask_q, mask_d;
    logic [NrClusters-1:0] sent_q, sent_d;
    logic [NrClusters-1:0] req_hs, fork_done;
    logic [NrClusters-1:0] fifo_push, fifo_pop, fifo_full, fifo_nempty;
    logic [NrClusters-1:0] head_err;
    logic [RespWidth-1:0]  head_data [NrClusters];
    logic [CntWidth-1:0]   out_q, out_d;
    logic                  credit, accept, merge_hs;
    logic [RespWidth-1:0]  sel_data;
    logic                  any_err, found;

    // Credit is taken from the registered count, so a merge in this cycle only
    // frees a slot for the following cycle.
    assign credit        = (out_q < MaxCnt);
    assign req_ready_o   = credit & req_valid_i & (&fork_done);
    assign accept        = req_ready_o;
    assign outstanding_o = out_q;
    assign busy_o        = (out_q != '0) | (|sent_q);

    // An inactive cluster never holds up the merge.
    assign resp_valid_o  = &(fifo_nempty | ~mask_q);
    assign merge_hs      = resp_valid_o & resp_ready_i;
    assign resp_data_o   = resp_valid_o ? sel_data : '0;
    assign resp_err_o    = resp_valid_o & any_err;

    for (genvar c = 0; c < NrClusters; c++) begin : g_clu
        logic [RespWidth:0]  mem_q [MaxOutstanding];
        logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
        logic [CntWidth-1:0] cnt_q;

        assign clu_req_data_o[c*ReqWidth +: ReqWidth] = req_data_i;
        assign clu_req_valid_o[c] = req_valid_i & mask_q[c] & ~sent_q[c] & credit;
        assign req_hs[c]          = clu_req_valid_o[c] & clu_req_ready_i[c];
        assign fork_done[c]       = ~mask_q[c] | sent_q[c] | req_hs[c];

        assign fifo_full[c]        = (cnt_q == MaxCnt);
        assign fifo_nempty[c]      = (cnt_q != '0);
        assign clu_resp_ready_o[c] = ~fifo_full[c];
        // Responses from masked-off clusters are acknowledged but never stored.
        assign fifo_push[c]        = clu_resp_valid_i[c] & ~fifo_full[c] & mask_q[c];
        assign fifo_pop[c]         = merge_hs & mask_q[c];
        assign head_data[c]        = mem_q[rd_ptr_q][RespWidth:1];
        assign head_err[c]         = mem_q[rd_ptr_q][0];

        always_ff @(posedge clk_i) begin
            if (fifo_push[c]) begin
                mem_q[wr_ptr_q] <= {clu_resp_data_i[c*RespWidth +: RespWidth], clu_resp_err_i[c]};
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (fifo_push[c]) begin
                    wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
                end
                if (fifo_pop[c]) begin
                    rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
                end
                case ({fifo_push[c], fifo_pop[c]})
                    2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                    2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    // Merged data comes from the lowest-index active cluster; errors are OR-ed.
    always_comb begin
        sel_data = '0;
        any_err  = 1'b0;
        found    = 1'b0;
        for (int c = 0; c < NrClusters; c++) begin
            if (mask_q[c]) begin
                if (!found) begin
                    sel_data = head_data[c];
                end
                found   = 1'b1;
                any_err = any_err | head_err[c];
            end
        end
    end

    always_comb begin
        mask_d = mask_q;
        if (!busy_o) begin
            mask_d = (active_mask_i == '0) ? NrClusters'(1) : active_mask_i;
        end
    end

    always_comb begin
        sent_d = sent_q | req_hs;
        if (accept) begin
            sent_d = '0;
        end
    end

    always_comb begin
        out_d = out_q;
        case ({accept, merge_hs})
            2'b10:   out_d = out_q + CntWidth'(1);
            2'b01:   out_d = out_q - CntWidth'(1);
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q <= '1;
            sent_q <= '0;
            out_q  <= '0;
        end else begin
            mask_q <= mask_d;
            sent_q <= sent_d;
            out_q  <= out_d;
        end
    end

`ifdef CLUSTER_DISPATCH_MISMATCH_CHECK_EN
    logic mismatch_q;
    logic heads_differ;

    always_comb begin
        heads_differ = 1'b0;
        for (int c = 0; c < NrClusters; c++) begin
            if (mask_q[c] && (head_data[c] != sel_data)) begin
                heads_differ = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_q | (merge_hs & heads_differ);
        end
    end

    assign mismatch_o = mismatch_q;
`else
    assign mismatch_o = 1'b0;
`endif

    // Every merged response pairs with an earlier accepted request.
    a_no_merge_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        merge_hs |-> (out_q != '0));

endmodule
